// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MIPS pipeline MEM stage. Issues sized loads/stores over a
//             req/ack data bus, extends load data, stalls upstream while an
//             access is outstanding and drives the MEM/WB pipeline register.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pstop_i,
    input  logic [31:0] alu_result,
    input  logic [31:0] b_value,
    input  logic [4:0]  dst_reg,
    input  logic [5:0]  opcode,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        wb_reg_write,
    input  logic        wb_mem_to_reg,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    output logic        dbus_we,
    output logic        dbus_req,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        mem_stall,
    output logic [31:0] mem_fwd_val,
    output logic        bus_err,
    output logic [31:0] MEM_WB_alu_result,
    output logic [31:0] MEM_WB_read_data,
    output logic [4:0]  MEM_WB_dst_reg,
    output logic        MEM_WB_wb_reg_write,
    output logic        MEM_WB_wb_mem_to_reg
);

    localparam logic [5:0] c_OP_LB  = 6'h20;
    localparam logic [5:0] c_OP_LH  = 6'h21;
    localparam logic [5:0] c_OP_LBU = 6'h24;
    localparam logic [5:0] c_OP_LHU = 6'h25;
    localparam logic [5:0] c_OP_SB  = 6'h28;
    localparam logic [5:0] c_OP_SH  = 6'h29;

    // Counter is 8 bits wide because TIMEOUT is limited to 1..255
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_bus_err;

    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_signed;
    logic        w_mem_op;
    logic        w_misaligned;
    logic        w_access;
    logic        w_req;
    logic        w_abort;
    logic        w_stall;
    logic        w_advance;
    logic        w_load_hit;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_ext;

    // Decode access size and signedness from the opcode; unknown opcodes are word
    always_comb begin
        w_is_byte = (opcode == c_OP_LB) || (opcode == c_OP_LBU) || (opcode == c_OP_SB);
        w_is_half = (opcode == c_OP_LH) || (opcode == c_OP_LHU) || (opcode == c_OP_SH);
        w_is_word = !w_is_byte && !w_is_half;
        w_signed  = (opcode == c_OP_LB) || (opcode == c_OP_LH);
    end

    // Alignment check and bus access qualification
    always_comb begin
        w_mem_op     = mem_read | mem_write;
        w_misaligned = w_mem_op &
                       ((w_is_half & alu_result[0]) |
                        (w_is_word & (alu_result[1:0] != 2'b00)));
        // Reset gates a fresh request so an abandoned access is not reissued
        w_access     = w_mem_op & ~w_misaligned & ~pstop_i & ~rst;
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = b_value;
        if (w_is_byte) begin
            w_be    = 4'b0001 << alu_result[1:0];
            w_wdata = {4{b_value[7:0]}};
        end else if (w_is_half) begin
            w_be    = alu_result[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{b_value[15:0]}};
        end
    end

    // Lane selection and sign/zero extension of read data
    always_comb begin
        case (alu_result[1:0])
            2'd0:    w_lane_byte = dbus_rdata[7:0];
            2'd1:    w_lane_byte = dbus_rdata[15:8];
            2'd2:    w_lane_byte = dbus_rdata[23:16];
            default: w_lane_byte = dbus_rdata[31:24];
        endcase
        w_lane_half = alu_result[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        if (w_is_byte)
            w_load_ext = w_signed ? {{24{w_lane_byte[7]}}, w_lane_byte}
                                  : {24'd0, w_lane_byte};
        else if (w_is_half)
            w_load_ext = w_signed ? {{16{w_lane_half[15]}}, w_lane_half}
                                  : {16'd0, w_lane_half};
        else
            w_load_ext = dbus_rdata;
    end

    // Request, abort and stall; stall drops in the cycle the access completes
    always_comb begin
        w_req      = (r_state == S_WAIT) ? 1'b1 : w_access;
        w_abort    = (r_state == S_WAIT) & ~dbus_ack & (r_cnt == c_TIMEOUT);
        w_stall    = w_req & ~dbus_ack & ~w_abort;
        // pstop only freezes the stage when no access is in flight
        w_advance  = ~w_stall & ((r_state == S_WAIT) | ~pstop_i);
        w_load_hit = w_req & dbus_ack & mem_read;
    end

    // Access FSM with wait counter and sticky bus error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access && !dbus_ack) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 8'd1;
                    end
                    if (w_misaligned && !pstop_i)
                        r_bus_err <= 1'b1;
                end
                S_WAIT: begin
                    if (dbus_ack) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 8'd0;
                    end else if (r_cnt == c_TIMEOUT) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= 8'd0;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    // MEM/WB register: capture on advance, bubble while stalled, hold on pstop
    always_ff @(posedge clk) begin
        if (rst) begin
            MEM_WB_alu_result    <= 32'd0;
            MEM_WB_read_data     <= 32'd0;
            MEM_WB_dst_reg       <= 5'd0;
            MEM_WB_wb_reg_write  <= 1'b0;
            MEM_WB_wb_mem_to_reg <= 1'b0;
        end else if (w_stall) begin
            MEM_WB_wb_reg_write  <= 1'b0;
            MEM_WB_wb_mem_to_reg <= 1'b0;
        end else if (w_advance) begin
            MEM_WB_alu_result    <= alu_result;
            MEM_WB_read_data     <= w_load_hit ? w_load_ext : 32'd0;
            MEM_WB_dst_reg       <= dst_reg;
            MEM_WB_wb_reg_write  <= wb_reg_write & ~w_misaligned;
            MEM_WB_wb_mem_to_reg <= wb_mem_to_reg;
        end
    end

    assign dbus_addr   = {alu_result[31:2], 2'b00};
    assign dbus_wdata  = w_wdata;
    assign dbus_be     = w_be;
    assign dbus_we     = mem_write;
    assign dbus_req    = w_req;
    assign mem_stall   = w_stall;
    assign mem_fwd_val = alu_result;
    assign bus_err     = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Directed self-checking bench for mem_stage (TIMEOUT = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        pstop_i;
    logic [31:0] alu_result;
    logic [31:0] b_value;
    logic [4:0]  dst_reg;
    logic [5:0]  opcode;
    logic        mem_read;
    logic        mem_write;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_we;
    logic        dbus_req;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        mem_stall;
    logic [31:0] mem_fwd_val;
    logic        bus_err;
    logic [31:0] MEM_WB_alu_result;
    logic [31:0] MEM_WB_read_data;
    logic [4:0]  MEM_WB_dst_reg;
    logic        MEM_WB_wb_reg_write;
    logic        MEM_WB_wb_mem_to_reg;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .pstop_i              (pstop_i),
        .alu_result           (alu_result),
        .b_value              (b_value),
        .dst_reg              (dst_reg),
        .opcode               (opcode),
        .mem_read             (mem_read),
        .mem_write            (mem_write),
        .wb_reg_write         (wb_reg_write),
        .wb_mem_to_reg        (wb_mem_to_reg),
        .dbus_addr            (dbus_addr),
        .dbus_wdata           (dbus_wdata),
        .dbus_be              (dbus_be),
        .dbus_we              (dbus_we),
        .dbus_req             (dbus_req),
        .dbus_rdata           (dbus_rdata),
        .dbus_ack             (dbus_ack),
        .mem_stall            (mem_stall),
        .mem_fwd_val          (mem_fwd_val),
        .bus_err              (bus_err),
        .MEM_WB_alu_result    (MEM_WB_alu_result),
        .MEM_WB_read_data     (MEM_WB_read_data),
        .MEM_WB_dst_reg       (MEM_WB_dst_reg),
        .MEM_WB_wb_reg_write  (MEM_WB_wb_reg_write),
        .MEM_WB_wb_mem_to_reg (MEM_WB_wb_mem_to_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] bval,
                         input logic rd, input logic wr, input logic rw, input logic m2r,
                         input logic [4:0] dst, input logic ack, input logic [31:0] rdata);
        opcode        = op;
        alu_result    = addr;
        b_value       = bval;
        mem_read      = rd;
        mem_write     = wr;
        wb_reg_write  = rw;
        wb_mem_to_reg = m2r;
        dst_reg       = dst;
        dbus_ack      = ack;
        dbus_rdata    = rdata;
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        pstop_i = 1'b0;
        drive(6'h00, 32'h0, 32'h0, 0, 0, 0, 0, 5'd0, 0, 32'h0);
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_alu",  MEM_WB_alu_result, 32'h0);
        check("rst_rd",   MEM_WB_read_data, 32'h0);
        check("rst_dst",  32'(MEM_WB_dst_reg), 32'h0);
        check("rst_rw",   32'(MEM_WB_wb_reg_write), 32'h0);
        check("rst_m2r",  32'(MEM_WB_wb_mem_to_reg), 32'h0);
        check("rst_req",  32'(dbus_req), 32'h0);
        check("rst_err",  32'(bus_err), 32'h0);
        rst = 1'b0;

        // lw 0x100, ack in the same cycle
        drive(6'h23, 32'h100, 32'h0, 1, 0, 1, 1, 5'd5, 1, 32'hDEADBEEF);
        #1;
        check("lw_req",   32'(dbus_req), 32'h1);
        check("lw_stall", 32'(mem_stall), 32'h0);
        check("lw_be",    32'(dbus_be), 32'hF);
        check("lw_addr",  dbus_addr, 32'h100);
        check("lw_we",    32'(dbus_we), 32'h0);
        check("lw_fwd",   mem_fwd_val, 32'h100);
        @(negedge clk);
        check("lw_rd",    MEM_WB_read_data, 32'hDEADBEEF);
        check("lw_rw",    32'(MEM_WB_wb_reg_write), 32'h1);
        check("lw_dst",   32'(MEM_WB_dst_reg), 32'h5);
        check("lw_m2r",   32'(MEM_WB_wb_mem_to_reg), 32'h1);
        check("lw_alu",   MEM_WB_alu_result, 32'h100);

        // lb 0x103, ack after three stall cycles
        drive(6'h20, 32'h103, 32'h0, 1, 0, 1, 1, 5'd6, 0, 32'h80123456);
        #1;
        check("lb_stall0", 32'(mem_stall), 32'h1);
        check("lb_be",     32'(dbus_be), 32'h8);
        check("lb_addr",   dbus_addr, 32'h100);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            check($sformatf("lb_stall%0d", i), 32'(mem_stall), 32'h1);
            check($sformatf("lb_bubble%0d", i), 32'(MEM_WB_wb_reg_write), 32'h0);
        end
        @(negedge clk);
        dbus_ack = 1'b1;
        #1;
        check("lb_ack_stall", 32'(mem_stall), 32'h0);
        @(negedge clk);
        check("lb_rd",  MEM_WB_read_data, 32'hFFFFFF80);
        check("lb_rw",  32'(MEM_WB_wb_reg_write), 32'h1);
        check("lb_dst", 32'(MEM_WB_dst_reg), 32'h6);

        // lbu 0x103
        drive(6'h24, 32'h103, 32'h0, 1, 0, 1, 1, 5'd6, 1, 32'h80123456);
        @(negedge clk);
        check("lbu_rd", MEM_WB_read_data, 32'h00000080);

        // lh 0x102 (upper half, negative)
        drive(6'h21, 32'h102, 32'h0, 1, 0, 1, 1, 5'd8, 1, 32'h80010000);
        #1;
        check("lh_be", 32'(dbus_be), 32'hC);
        @(negedge clk);
        check("lh_rd", MEM_WB_read_data, 32'hFFFF8001);

        // lhu 0x100 (lower half)
        drive(6'h25, 32'h100, 32'h0, 1, 0, 1, 1, 5'd8, 1, 32'h1234F00D);
        #1;
        check("lhu_be", 32'(dbus_be), 32'h3);
        @(negedge clk);
        check("lhu_rd", MEM_WB_read_data, 32'h0000F00D);

        // sh 0x102
        drive(6'h29, 32'h102, 32'h1234ABCD, 0, 1, 0, 0, 5'd0, 1, 32'h0);
        #1;
        check("sh_wdata", dbus_wdata, 32'hABCDABCD);
        check("sh_be",    32'(dbus_be), 32'hC);
        check("sh_we",    32'(dbus_we), 32'h1);
        check("sh_req",   32'(dbus_req), 32'h1);
        @(negedge clk);
        check("sh_rw",    32'(MEM_WB_wb_reg_write), 32'h0);

        // sb 0x101
        drive(6'h28, 32'h101, 32'h000000A5, 0, 1, 0, 0, 5'd0, 1, 32'h0);
        #1;
        check("sb_wdata", dbus_wdata, 32'hA5A5A5A5);
        check("sb_be",    32'(dbus_be), 32'h2);
        @(negedge clk);

        // misaligned lw 0x102
        drive(6'h23, 32'h102, 32'h0, 1, 0, 1, 1, 5'd3, 0, 32'h0);
        #1;
        check("mis_req",   32'(dbus_req), 32'h0);
        check("mis_stall", 32'(mem_stall), 32'h0);
        @(negedge clk);
        check("mis_err",   32'(bus_err), 32'h1);
        check("mis_rw",    32'(MEM_WB_wb_reg_write), 32'h0);

        // reset clears the sticky error
        rst = 1'b1;
        drive(6'h00, 32'h0, 32'h0, 0, 0, 0, 0, 5'd0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("rst2_err", 32'(bus_err), 32'h0);

        // lw 0x200 with no ack: four stall cycles then abort
        drive(6'h23, 32'h200, 32'h0, 1, 0, 1, 1, 5'd4, 0, 32'h12345678);
        #1;
        check("to_stall0", 32'(mem_stall), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("to_stall%0d", i), 32'(mem_stall), 32'h1);
        end
        check("to_err_pre", 32'(bus_err), 32'h0);
        @(negedge clk);
        check("to_release", 32'(mem_stall), 32'h0);
        check("to_req",     32'(dbus_req), 32'h1);
        @(negedge clk);
        drive(6'h00, 32'h0, 32'h0, 0, 0, 0, 0, 5'd0, 0, 32'h0);
        check("to_rd",  MEM_WB_read_data, 32'h0);
        check("to_err", 32'(bus_err), 32'h1);
        @(negedge clk);
        check("to_err_sticky", 32'(bus_err), 32'h1);

        // pstop with a pending ALU op freezes MEM/WB
        drive(6'h00, 32'h55, 32'h0, 0, 0, 1, 0, 5'd7, 0, 32'h0);
        @(negedge clk);
        check("alu_res", MEM_WB_alu_result, 32'h55);
        check("alu_dst", 32'(MEM_WB_dst_reg), 32'h7);
        pstop_i = 1'b1;
        drive(6'h23, 32'h400, 32'h0, 1, 0, 1, 1, 5'd9, 0, 32'h0);
        #1;
        check("ps_req",   32'(dbus_req), 32'h0);
        check("ps_stall", 32'(mem_stall), 32'h0);
        @(negedge clk);
        check("ps_alu", MEM_WB_alu_result, 32'h55);
        check("ps_dst", 32'(MEM_WB_dst_reg), 32'h7);
        check("ps_rw",  32'(MEM_WB_wb_reg_write), 32'h1);
        check("ps_m2r", 32'(MEM_WB_wb_mem_to_reg), 32'h0);
        pstop_i = 1'b0;

        // reset asserted while an access is waiting
        #1;
        check("rw_req", 32'(dbus_req), 32'h1);
        @(negedge clk);
        check("rw_stall", 32'(mem_stall), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rw_req0", 32'(dbus_req), 32'h0);
        check("rw_alu",  MEM_WB_alu_result, 32'h0);
        check("rw_dst",  32'(MEM_WB_dst_reg), 32'h0);
        check("rw_rw",   32'(MEM_WB_wb_reg_write), 32'h0);
        check("rw_err",  32'(bus_err), 32'h0);
        check("rw_stl",  32'(mem_stall), 32'h0);
        rst = 1'b0;
        drive(6'h00, 32'h0, 32'h0, 0, 0, 0, 0, 5'd0, 0, 32'h0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
